mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Booth multiplier (datapath plus control unit) among `NREQ` requesters. It selects one pending request, latches that requester's operands and pulses the multiplier's `start`. It then waits for the multiplier's `valid` and returns the product to the winning requester with a one-cycle `done`. It sits between the requesting units and the single multiplier instance.

---
 rtl/mult_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter and sequencer sharing one Booth multiplier
//               among NREQ requesters. Picks a pending request, latches that
//               requester's operands, pulses mul_start, waits for mul_valid
//               and returns the product with a one-cycle done pulse.
//               Optional watchdog on the WAIT state: define
//               MULT_ARB_TIMEOUT_EN to abort after TMO WAIT cycles with err.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
   parameter int nb   = 4,
   parameter int NREQ = 4,
   parameter int TMO  = 4*nb
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*nb-1:0] a_in,
   input  logic [NREQ*nb-1:0] b_in,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    done,
   output logic [2*nb-1:0]    result,
   output logic               err,
   output logic               busy,
   output logic               mul_start,
   output logic [nb-1:0]      mul_a,
   output logic [nb-1:0]      mul_b,
   input  logic               mul_valid,
   input  logic [2*nb-1:0]    mul_product
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   sel_idx;
   logic            sel_found;
   logic [NREQ-1:0] idx_onehot;
   logic            timeout_hit;

   assign idx_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;

   // Round-robin search: first requester at or above ptr, wrapping to 0
   always_comb begin
      int j;
      j         = 0;
      sel_idx   = ptr;
      sel_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         if (!sel_found && req[j]) begin
            sel_idx   = PW'(j);
            sel_found = 1'b1;
         end
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0] wait_cnt;
   logic          tmo_flag;

   assign timeout_hit = (state == S_WAIT) && !mul_valid && (wait_cnt == CW'(TMO - 1));
   assign err         = (state == S_RESP) && tmo_flag;

   // Watchdog: count WAIT cycles without mul_valid; flag an abort for RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         tmo_flag <= 1'b0;
      end else if (state == S_ISSUE) begin
         wait_cnt <= '0;
         tmo_flag <= 1'b0;
      end else if (state == S_WAIT) begin
         if (timeout_hit) begin
            tmo_flag <= 1'b1;
         end else if (!mul_valid) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end
`else
   // TMO is a positive count, so this is constant 0: WAIT ends only on mul_valid
   assign timeout_hit = (TMO < 0);
   assign err         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control outputs decoded from the current state
   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      grant     = '0;
      done      = '0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            if (sel_found) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mul_start = 1'b1;
            grant     = idx_onehot;
            busy      = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            grant = idx_onehot;
            busy  = 1'b1;
            if (mul_valid || timeout_hit) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            grant     = idx_onehot;
            done      = idx_onehot;
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: operand latch in IDLE, product capture in WAIT, pointer advance in RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= '0;
         idx    <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  idx   <= sel_idx;
                  mul_a <= a_in[sel_idx*nb +: nb];
                  mul_b <= b_in[sel_idx*nb +: nb];
               end
            end
            S_WAIT: begin
               if (mul_valid) begin
                  result <= mul_product;
               end else if (timeout_hit) begin
                  result <= '0;
               end
            end
            S_RESP: begin
               ptr <= (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter with a behavioural
//               multiplier stub and a cycle-timed round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

   localparam int NB    = 4;
   localparam int NR    = 4;
   localparam int TMO_V = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [15:0]   a_in;
   logic [15:0]   b_in;
   logic [NR-1:0] grant;
   logic [NR-1:0] done;
   logic [7:0]    result;
   logic          err;
   logic          busy;
   logic          mul_start;
   logic [3:0]    mul_a;
   logic [3:0]    mul_b;
   logic          mul_valid = 1'b0;
   logic [7:0]    mul_product = 8'h00;

   mult_arbiter #(.nb(NB), .NREQ(NR), .TMO(TMO_V)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .a_in        (a_in),
      .b_in        (b_in),
      .grant       (grant),
      .done        (done),
      .result      (result),
      .err         (err),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_valid   (mul_valid),
      .mul_product (mul_product)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Two's-complement nb x nb product, computed with integer arithmetic
   function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
      int x;
      int y;
      x = a[3] ? int'(a) - 16 : int'(a);
      y = b[3] ? int'(b) - 16 : int'(b);
      return 8'(x * y);
   endfunction

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         if (r[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   // ---------------- multiplier stub: sticky valid, cleared on start ---------
   int   stub_lat   = 1;
   int   stub_cnt   = 0;
   logic stub_never = 1'b0;
   int   force_lat  = 0;

   always @(posedge clk) begin
      if (mul_start) begin
         mul_valid   <= 1'b0;
         mul_product <= smul(mul_a, mul_b);
         stub_cnt    <= stub_lat;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1 && !stub_never) mul_valid <= 1'b1;
      end
   end

   // ---------------- reference model + per-cycle checks ----------------------
   int         cyc      = 0;
   int         sel_cyc  = -100;
   int         done_cyc = -100;
   int         win      = 0;
   int         mptr     = 0;
   logic [3:0] exp_a    = '0;
   logic [3:0] exp_b    = '0;
   logic [7:0] exp_prod = '0;
   logic       exp_err  = 1'b0;
   logic [7:0] last_res = '0;
   int         win_log[$];
   logic [7:0] res_log[$];

   always @(negedge clk) begin
      logic in_flight;
      logic issue;
      logic [3:0] oh;
      cyc++;
      if (rst) begin
         mptr     = 0;
         sel_cyc  = -100;
         done_cyc = -100;
         last_res = '0;
         check_val("rst_grant", grant, 0);
         check_val("rst_done", done, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_start", mul_start, 0);
         check_val("rst_result", result, 0);
         check_val("rst_ops", {mul_a, mul_b}, 0);
         check_val("rst_err", err, 0);
      end else begin
         in_flight = (cyc > sel_cyc) && (cyc <= done_cyc);
         issue     = (cyc == sel_cyc + 1);
         oh        = 4'(1 << win);
         if (cyc == done_cyc) last_res = exp_prod;
         check_val("start", mul_start, issue);
         check_val("grant", grant, in_flight ? oh : 4'b0);
         check_val("busy", busy, in_flight);
         check_val("done", done, (cyc == done_cyc) ? oh : 4'b0);
         check_val("err", err, (cyc == done_cyc) && exp_err);
         check_val("result", result, last_res);
         if (issue) begin
            check_val("mul_a", mul_a, exp_a);
            check_val("mul_b", mul_b, exp_b);
         end
         if (cyc == done_cyc) begin
            win_log.push_back(win);
            res_log.push_back(result);
            mptr = (win + 1) % NR;
         end
         if (!in_flight && req != 0) begin
            win      = rr_pick(req, mptr);
            exp_a    = a_in[win*4 +: 4];
            exp_b    = b_in[win*4 +: 4];
            sel_cyc  = cyc;
            stub_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
            exp_err  = 1'b0;
            exp_prod = smul(exp_a, exp_b);
            done_cyc = cyc + stub_lat + 3;
            if (stub_never) begin
`ifdef MULT_ARB_TIMEOUT_EN
               done_cyc = cyc + TMO_V + 2;
               exp_err  = 1'b1;
               exp_prod = 8'h00;
`else
               done_cyc = 1 << 30;
`endif
            end
         end
      end
   end

   function automatic int log_win(input int k);
      return (k < win_log.size()) ? win_log[k] : -1;
   endfunction

   function automatic int log_res(input int k);
      return (k < res_log.size()) ? int'(res_log[k]) : -1;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------------------------------------
   initial begin
      int base;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      rst = 1'b1; req = '0; a_in = '0; b_in = '0;
      cycles(3);
      rst = 1'b0;

      // single requester 2: 3 x -2
      base = win_log.size();
      a_in = 16'h0300; b_in = 16'h0E00; req = 4'b0100;
      cycles(1); req = '0;
      cycles(12);
      check_val("tc1_winner", log_win(base), 2);
      check_val("tc1_result", result, 8'hFA);
      // pointer now 3: of {0,3}, 3 wins
      a_in = 16'h5004; b_in = 16'h3002; req = 4'b1001;
      cycles(1); req = '0;
      cycles(12);
      check_val("tc1_ptr_next", log_win(base + 1), 3);

      // req 1010 from ptr 0: 1 then 3
      do_reset();
      base = win_log.size();
      a_in = 16'h7030; b_in = 16'h7030; req = 4'b1010;
      repeat (30) begin
         @(posedge clk); #1 req = req & ~done;
      end
      check_val("tc2_first", log_win(base), 1);
      check_val("tc2_res1", log_res(base), 8'h09);
      check_val("tc2_second", log_win(base + 1), 3);
      check_val("tc2_res2", log_res(base + 1), 8'h31);

      // all requesters held continuously
      do_reset();
      base = win_log.size();
      a_in = 16'h9A5C; b_in = 16'h36F1; req = 4'b1111;
      cycles(50);
      req = '0;
      cycles(12);
      for (int k = 0; k < 5; k++) check_val("tc3_order", log_win(base + k), exp_order[k]);

      // reset during WAIT
      do_reset();
      force_lat = 6;
      a_in = 16'h0050; b_in = 16'h0060; req = 4'b0010;
      cycles(1); req = '0;
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_val("tc5_busy", busy, 0);
      check_val("tc5_grant", grant, 0);
      check_val("tc5_done", done, 0);
      check_val("tc5_ops", {mul_a, mul_b}, 0);
      check_val("tc5_start", mul_start, 0);
      @(posedge clk); #1 rst = 1'b0;
      force_lat = 0;
      base = win_log.size();
      req = 4'b1001;
      cycles(1); req = '0;
      cycles(12);
      check_val("tc5_restart", log_win(base), 0);

      // multiplier never answers
      do_reset();
      stub_never = 1'b1;
      base = win_log.size();
      a_in = 16'h0700; b_in = 16'h0300; req = 4'b0100;
      cycles(1); req = '0;
      cycles(30);
`ifdef MULT_ARB_TIMEOUT_EN
      check_val("tc6_tmo_done", win_log.size() - base, 1);
      check_val("tc6_tmo_res", result, 0);
`else
      check_val("tc6_busy", busy, 1);
      check_val("tc6_nodone", win_log.size() - base, 0);
`endif
      stub_never = 1'b0;
      do_reset();

      // randomized traffic
      for (int t = 0; t < 600; t++) begin
         @(posedge clk); #1;
         a_in = 16'($urandom);
         b_in = 16'($urandom);
         for (int i = 0; i < NR; i++) begin
            if (req[i] && done[i]) req[i] = ($urandom_range(0, 1) == 0);
            else if (req[i])       req[i] = ($urandom_range(0, 15) != 0);
            else                   req[i] = ($urandom_range(0, 3) == 0);
         end
      end
      req = '0;
      cycles(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
